// File: rtl/bsg_mcl_tx_packer.sv
// Packs in_width_p-bit host words into one out_width_p-bit manycore-link request packet,
// holds it for a valid/ready drain, and reports TX vacancy and transmit-complete.

module bsg_mcl_tx_packer_chk #(
   parameter int out_width_p = 128,
   parameter int words_lp    = 4,
   parameter int cnt_w_lp    = 2
) (
   input logic                   clk_i,
   input logic                   reset_n_i,
   input logic                   out_v_i,
   input logic                   out_ready_i,
   input logic [out_width_p-1:0] out_data_i,
   input logic [cnt_w_lp-1:0]    cnt_i
);

   hold_stable_a: assert property (@(posedge clk_i)
      (reset_n_i && out_v_i && !out_ready_i) |=> (out_v_i && $stable(out_data_i)))
      else $error("held packet changed before drain");

   cnt_range_a: assert property (@(posedge clk_i) (32'(cnt_i) < 32'(words_lp)))
      else $error("staging count out of range");

endmodule

module bsg_mcl_tx_packer #(
   parameter int in_width_p  = 32,
   parameter int out_width_p = 128
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   flush_i,
   input  logic                   in_v_i,
   input  logic [in_width_p-1:0]  in_data_i,
   output logic                   in_ready_o,
   output logic                   out_v_o,
   output logic [out_width_p-1:0] out_data_o,
   input  logic                   out_ready_i,
   output logic [31:0]            tdfv_o,
   output logic                   tx_complete_o,
   output logic [31:0]            pkt_count_o
);

   localparam int words_lp   = out_width_p / in_width_p;
   localparam int cnt_w_lp   = $clog2(words_lp);
   localparam int stage_w_lp = out_width_p - in_width_p;
   localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(words_lp - 1);

   logic [cnt_w_lp-1:0]    cnt_r, cnt_s;
   logic [stage_w_lp-1:0]  stage_r, stage_s;
   logic                   out_v_r, out_v_s;
   logic [out_width_p-1:0] out_data_r, out_data_s;
   logic                   tx_complete_r, tx_complete_s;
   logic [31:0]            pkt_count_r, pkt_count_s;
   logic                   in_ready_r, in_ready_s;
   logic [31:0]            tdfv_r, tdfv_s;
   logic                   accept_s, drain_s;

   // Next-state: staging, packet load/drain, and the flow-control/vacancy view of that state.
   always_comb begin
      cnt_s         = cnt_r;
      stage_s       = stage_r;
      out_v_s       = out_v_r;
      out_data_s    = out_data_r;
      tx_complete_s = 1'b0;
      pkt_count_s   = pkt_count_r;
      accept_s      = in_v_i & in_ready_r;
      drain_s       = out_v_r & out_ready_i;

      // A flush wins over a same-cycle word; the held packet is already committed.
      if (flush_i) begin
         cnt_s = '0;
      end else if (accept_s) begin
         if (cnt_r == last_cnt_lp) begin
            out_v_s    = 1'b1;
            out_data_s = {in_data_i, stage_r};
            cnt_s      = '0;
         end else begin
            stage_s[in_width_p*cnt_r +: in_width_p] = in_data_i;
            cnt_s = cnt_r + cnt_w_lp'(1);
         end
      end else begin
         cnt_s = cnt_r;
      end

      // in_ready gating keeps a load and a drain from landing on the same edge.
      if (drain_s) begin
         out_v_s       = 1'b0;
         tx_complete_s = 1'b1;
         pkt_count_s   = pkt_count_r + 32'd1;
      end else begin
         tx_complete_s = 1'b0;
      end

      in_ready_s = (cnt_s != last_cnt_lp) | ~out_v_s;
      tdfv_s     = (out_v_s ? 32'd0 : 32'(words_lp)) + 32'(words_lp) - 32'(cnt_s);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt_r         <= '0;
         stage_r       <= '0;
         out_v_r       <= 1'b0;
         out_data_r    <= '0;
         tx_complete_r <= 1'b0;
         pkt_count_r   <= 32'd0;
         in_ready_r    <= 1'b1;
         tdfv_r        <= 32'(2 * words_lp);
      end else begin
         cnt_r         <= cnt_s;
         stage_r       <= stage_s;
         out_v_r       <= out_v_s;
         out_data_r    <= out_data_s;
         tx_complete_r <= tx_complete_s;
         pkt_count_r   <= pkt_count_s;
         in_ready_r    <= in_ready_s;
         tdfv_r        <= tdfv_s;
      end
   end

   assign in_ready_o    = in_ready_r;
   assign out_v_o       = out_v_r;
   assign out_data_o    = out_data_r;
   assign tdfv_o        = tdfv_r;
   assign tx_complete_o = tx_complete_r;
   assign pkt_count_o   = pkt_count_r;

   bsg_mcl_tx_packer_chk #(
      .out_width_p(out_width_p),
      .words_lp   (words_lp),
      .cnt_w_lp   (cnt_w_lp)
   ) chk (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .out_v_i    (out_v_r),
      .out_ready_i(out_ready_i),
      .out_data_i (out_data_r),
      .cnt_i      (cnt_r)
   );

endmodule

// File: tb/tb_bsg_mcl_tx_packer.sv
// Directed and random stimulus for bsg_mcl_tx_packer, checked every cycle against a
// word-queue reference model.

module tb_bsg_mcl_tx_packer;

   logic         clk_i = 1'b0;
   logic         reset_n_i = 1'b0;
   logic         flush_i = 1'b0;
   logic         in_v_i = 1'b0;
   logic [31:0]  in_data_i = 32'd0;
   logic         in_ready_o;
   logic         out_v_o;
   logic [127:0] out_data_o;
   logic         out_ready_i = 1'b0;
   logic [31:0]  tdfv_o;
   logic         tx_complete_o;
   logic [31:0]  pkt_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: words staged since last flush/reset, plus the held packet
   logic [31:0]  m_words[$];
   logic         m_held_v = 1'b0;
   logic [127:0] m_held   = 128'd0;
   logic         m_txc    = 1'b0;
   logic [31:0]  m_pkts   = 32'd0;

   bsg_mcl_tx_packer #(.in_width_p(32), .out_width_p(128)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .flush_i      (flush_i),
      .in_v_i       (in_v_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .out_v_o      (out_v_o),
      .out_data_o   (out_data_o),
      .out_ready_i  (out_ready_i),
      .tdfv_o       (tdfv_o),
      .tx_complete_o(tx_complete_o),
      .pkt_count_o  (pkt_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare every output.
   task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                       input logic fl, input logic rst_n);
      logic m_ready, acc, drn;
      in_v_i      = v;
      in_data_i   = d;
      out_ready_i = rdy;
      flush_i     = fl;
      reset_n_i   = rst_n;
      m_ready = (m_words.size() != 3) || !m_held_v;
      acc     = v && m_ready;
      drn     = m_held_v && rdy;
      @(posedge clk_i);
      #1;
      if (!rst_n) begin
         m_words.delete();
         m_held_v = 1'b0;
         m_held   = 128'd0;
         m_txc    = 1'b0;
         m_pkts   = 32'd0;
      end else begin
         m_txc = drn;
         if (drn) begin
            m_held_v = 1'b0;
            m_pkts   = m_pkts + 32'd1;
         end
         if (fl) m_words.delete();
         else if (acc) begin
            m_words.push_back(d);
            if (m_words.size() == 4) begin
               m_held   = {m_words[3], m_words[2], m_words[1], m_words[0]};
               m_held_v = 1'b1;
               m_words.delete();
            end
         end
      end
      m_ready = (m_words.size() != 3) || !m_held_v;
      chk("in_ready", 128'(in_ready_o), 128'(m_ready));
      chk("out_v", 128'(out_v_o), 128'(m_held_v));
      chk("out_data", out_data_o, m_held);
      chk("tdfv", 128'(tdfv_o), 128'((m_held_v ? 0 : 4) + (4 - m_words.size())));
      chk("tx_complete", 128'(tx_complete_o), 128'(m_txc));
      chk("pkt_count", 128'(pkt_count_o), 128'(m_pkts));
   endtask

   initial begin
      logic [31:0]  w[8];
      logic [127:0] snap;
      int           steps;

      // reset
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_tdfv", 128'(tdfv_o), 128'd8);
      chk("rst_ready", 128'(in_ready_o), 128'd1);

      // first packet, word order
      step(1'b1, 32'h0000_0A01, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h0000_3003, 1'b1, 1'b0, 1'b1);
      chk("t1_pkt", out_data_o, 128'h00003003_00000002_00000001_00000A01);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("t1_txc", 128'(tx_complete_o), 128'd1);
      chk("t1_count", 128'(pkt_count_o), 128'd1);

      // backpressure: 7 words with ready low, 8th stalls until drain
      for (int i = 0; i < 8; i++) w[i] = 32'h1000_0000 + 32'(i);
      for (int i = 0; i < 7; i++) step(1'b1, w[i], 1'b0, 1'b0, 1'b1);
      chk("t2_tdfv7", 128'(tdfv_o), 128'd1);
      step(1'b1, w[7], 1'b0, 1'b0, 1'b1);
      chk("t2_stall", 128'(in_ready_o), 128'd0);
      step(1'b1, w[7], 1'b1, 1'b0, 1'b1);
      step(1'b1, w[7], 1'b1, 1'b0, 1'b1);
      chk("t2_pkt2", out_data_o, {w[7], w[6], w[5], w[4]});
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("t2_count", 128'(pkt_count_o), 128'd3);

      // flush discards a partial packet
      step(1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'hDEAD_0002, 1'b1, 1'b0, 1'b1);
      chk("t3_tdfv6", 128'(tdfv_o), 128'd6);
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
      chk("t3_tdfv8", 128'(tdfv_o), 128'd8);
      step(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
      chk("t3_pkt", out_data_o, 128'h0000000D_0000000C_0000000B_0000000A);

      // hold with ready low while input data toggles
      snap = out_data_o;
      for (int i = 0; i < 50; i++) step(1'b0, $urandom(), 1'b0, 1'b0, 1'b1);
      chk("t4_hold", out_data_o, snap);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

      // reset with a held packet and 3 staged words, ready high at the reset edge
      for (int i = 0; i < 7; i++) step(1'b1, $urandom(), 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("t5_outv", 128'(out_v_o), 128'd0);
      chk("t5_tdfv", 128'(tdfv_o), 128'd8);
      chk("t5_count", 128'(pkt_count_o), 128'd0);
      chk("t5_txc", 128'(tx_complete_o), 128'd0);

      // random traffic until 1000 packets have drained
      steps = 0;
      while (m_pkts < 32'd1000 && steps < 40000) begin
         step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 299) == 0, 1'b1);
         steps++;
      end
      chk("t6_count", 128'(pkt_count_o), 128'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
